serializer_word_scheduler: RTL and testbench
============================================

# serializer_word_scheduler

Round-robin scheduler that shares the 32-to-8 byte serializer between NUM_REQ word requesters. It accepts 32-bit words over req/ack handshakes and drives the serializer's load strobe (tx_out) and 32-bit data word. Strobes are spaced so that a loaded word is never overwritten while its four bytes are being emitted. It also produces byte-lane sideband (valid, index, source) aligned with the serializer's byte output.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WORD_W, 32, word width; fixed at 32, the serializer emits 4 bytes per word
- CNT_W, 16, width of the launched-word counter
- div_8_clk  in  1  clock shared with the serializer
- rst_n  in  1  synchronous, active-low reset
- sched_en  in  1  1 = launches allowed; 0 = finish the current frame, then hold in IDLE
- req  in  NUM_REQ  per-requester word request; held high until the matching ack
- req_data  in  NUM_REQ*WORD_W  packed words; requester i uses bits [i*32 +: 32]; stable while req[i]=1
- req_ack  out  NUM_REQ  one-cycle, one-hot acceptance pulse
- tx_out  out  1  serializer load strobe; one cycle per word
- tx_word  out  WORD_W  word presented to the serializer data input
- byte_valid  out  1  high on the 4 cycles the serializer drives a byte
- byte_idx  out  2  byte index 0..3 (0 = bits [7:0]) while byte_valid=1, else 0
- byte_src  out  3  requester id of the current frame while byte_valid=1, else 0
- busy  out  1  high in LAUNCH and HOLD
- words_sent  out  CNT_W  count of launched words; wraps modulo 2^CNT_W

## Operation
- States: IDLE, LAUNCH, HOLD.
- Arbitration:
  - Evaluated in IDLE, and in the last HOLD cycle (hold_cnt=3).
  - Only when sched_en=1 and req is non-zero.
  - Round-robin from pointer ptr: the first set req[i] in order ptr, ptr+1, … mod NUM_REQ wins.
  - After reset, ptr=0. After a grant to i, ptr becomes (i+1) mod NUM_REQ.
- Grant edge: on the clock edge where arbitration yields winner g:
  - gnt_id<=g and tx_word<=req_data[g].
  - ptr updates.
  - The state goes to LAUNCH.
- LAUNCH (1 cycle):
  - tx_out=1 and req_ack[g]=1.
  - words_sent increments.
  - Next state is HOLD, with hold_cnt=0.
- HOLD (4 cycles, hold_cnt 0..3):
  - tx_out=0; tx_word is held.
  - byte_valid=1, byte_idx=hold_cnt, byte_src=gnt_id.
  - At hold_cnt=3: go to LAUNCH if arbitration yields a winner, else IDLE.
- tx_out is never high in HOLD. This protects the serializer buffer, which reloads on any tx_out.
- sched_en deasserted mid-frame: the current frame completes all 4 HOLD cycles and no further launch occurs. Reassertion in IDLE allows arbitration on the same cycle.
- A req dropped before its ack is a protocol violation. The scheduler does not check for it; the captured word is still sent.
- A req bit for an index ≥ NUM_REQ does not exist. A requester whose req stays high after its ack is treated as a new request.

## Timing
- Reset, synchronous on rst_n=0 at a clock edge:
  - state=IDLE, ptr=0, hold_cnt=0.
  - tx_out=0, tx_word=0, req_ack=0, byte_valid=0, byte_idx=0, byte_src=0, busy=0, words_sent=0.
- Reset asserted mid-frame aborts the frame at that edge. No ack is issued afterwards for the aborted frame.
- Request to strobe: req rising in IDLE at cycle t (sampled at edge t+1) gives LAUNCH and tx_out=1 in cycle t+1.
- Strobe to bytes: for tx_out in cycle L, byte_valid covers cycles L+1..L+4. This matches the serializer S_0..S_3 states.
- Back-to-back: minimum strobe spacing is 5 cycles. With continuous requests the serializer emits 4 bytes per 5 cycles and never waits in idle between frames.
- req_ack coincides with tx_out; the requester may change req_data from the following cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from req to any output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-stream -> all outputs 0 on the cycle after the reset edge; the first grant after release goes to the lowest-index requester at or after 0.
- Single word: req[2]=1 with data 0xA1B2C3D4 from IDLE -> tx_out and req_ack=4'b0100 in the next cycle. byte_src=2 and byte_idx=0,1,2,3 on the following 4 cycles. words_sent=1.
- Round-robin: req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0. tx_out period exactly 5 cycles; never high while byte_valid=1.
- Fairness skip: ptr=1 with req=4'b1001 -> requester 3 wins, then requester 0 wins.
- sched_en drop: deassert during hold_cnt=1 of the frame of requester 0 -> bytes 1..3 complete, IDLE follows, no ack to pending requesters. Reassert -> launch in the next cycle.
- Counter wrap: CNT_W=4 with 17 launches -> words_sent reads 1.

Source files
------------

// File: rtl/serializer_word_scheduler.sv
// serializer_word_scheduler: round-robin word scheduler feeding a 32-to-8 byte serializer
module serializer_word_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      div_8_clk,
  input  logic                      rst_n,
  input  logic                      sched_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_out,
  output logic [WORD_W-1:0]         tx_word,
  output logic                      byte_valid,
  output logic [1:0]                byte_idx,
  output logic [2:0]                byte_src,
  output logic                      busy,
  output logic [CNT_W-1:0]          words_sent
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, gnt_id, win;
  logic [1:0] hold_cnt;
  logic [WORD_W-1:0] win_word;
  logic arb;
  int d, best_d;
  assign arb = sched_en && |req && (state == IDLE || (state == HOLD && hold_cnt == 2'd3));
  // winner is the requester with the smallest round-robin distance from ptr
  always_comb begin
    win = '0;
    win_word = '0;
    d = 0;
    best_d = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[i] && d < best_d) begin
        best_d = d;
        win = IDW'(i);
        win_word = req_data[i*WORD_W +: WORD_W];
      end
    end
  end
  always_ff @(posedge div_8_clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = (state == LAUNCH) ? HOLD :
               (state == HOLD && hold_cnt != 2'd3) ? HOLD :
               arb ? LAUNCH : IDLE;
  always_ff @(posedge div_8_clk) begin
    if (!rst_n) begin
      ptr <= '0;
      gnt_id <= '0;
      hold_cnt <= '0;
      tx_word <= '0;
      words_sent <= '0;
    end else begin
      hold_cnt <= (state == HOLD) ? hold_cnt + 2'd1 : 2'd0;
      if (state == LAUNCH) words_sent <= words_sent + CNT_W'(1);
      if (arb) begin
        gnt_id <= win;
        tx_word <= win_word;
        ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
      end
    end
  end
  always_comb begin
    tx_out = state == LAUNCH;
    req_ack = (state == LAUNCH) ? NUM_REQ'(1) << gnt_id : '0;
    byte_valid = state == HOLD;
    byte_idx = (state == HOLD) ? hold_cnt : 2'd0;
    byte_src = (state == HOLD) ? 3'(gnt_id) : 3'd0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_serializer_word_scheduler.sv
// tb_serializer_word_scheduler: table vectors, directed corners and a randomized run against a timeline model
module tb_serializer_word_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  localparam int MC = 8192;
  typedef struct {
    bit rst_n; bit en; bit [N-1:0] req;
    bit tx; bit [N-1:0] ack; bit bv; bit [1:0] idx; bit [2:0] src; bit busy; bit [31:0] word; int cnt;
  } vec_t;
  logic div_8_clk = 1'b0;
  always #5 div_8_clk = ~div_8_clk;
  logic rst_n, sched_en;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ack, w_req_ack;
  logic tx_out, byte_valid, busy, w_tx_out, w_byte_valid, w_busy;
  logic [W-1:0] tx_word, w_tx_word;
  logic [1:0] byte_idx, w_byte_idx;
  logic [2:0] byte_src, w_byte_src;
  logic [15:0] words_sent;
  logic [3:0] w_words_sent;
  serializer_word_scheduler #(.NUM_REQ(N), .WORD_W(W), .CNT_W(16)) u_dut (
    .div_8_clk(div_8_clk), .rst_n(rst_n), .sched_en(sched_en), .req(req), .req_data(req_data),
    .req_ack(req_ack), .tx_out(tx_out), .tx_word(tx_word), .byte_valid(byte_valid),
    .byte_idx(byte_idx), .byte_src(byte_src), .busy(busy), .words_sent(words_sent));
  serializer_word_scheduler #(.NUM_REQ(N), .WORD_W(W), .CNT_W(4)) u_wrap (
    .div_8_clk(div_8_clk), .rst_n(rst_n), .sched_en(sched_en), .req(req), .req_data(req_data),
    .req_ack(w_req_ack), .tx_out(w_tx_out), .tx_word(w_tx_word), .byte_valid(w_byte_valid),
    .byte_idx(w_byte_idx), .byte_src(w_byte_src), .busy(w_busy), .words_sent(w_words_sent));

  // expected per-cycle outputs, booked ahead whenever the model grants a word
  bit m_tx[MC], m_bv[MC], m_busy[MC], m_wset[MC], m_inc[MC], m_rst[MC];
  bit [N-1:0] m_ack[MC];
  bit [1:0] m_idx[MC];
  bit [2:0] m_src[MC];
  bit [31:0] m_wval[MC];
  int cyc = 0, m_ptr = 0, m_allow = 0, n_cmp = 0, n_fail = 0;
  int unsigned m_cnt = 0;
  bit [31:0] m_word = '0;
  bit armed = 0;
  vec_t tv[23];

  function void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function void model_edge();
    int g, l;
    if (!rst_n) begin
      for (int k = cyc + 1; k < cyc + 9; k++) begin
        m_tx[k] = 0; m_bv[k] = 0; m_busy[k] = 0; m_wset[k] = 0; m_inc[k] = 0;
        m_rst[k] = 0; m_ack[k] = '0; m_idx[k] = '0; m_src[k] = '0;
      end
      m_ptr = 0; m_allow = cyc + 1; m_rst[cyc+1] = 1; armed = 1;
    end else if (sched_en && req != '0 && cyc >= m_allow) begin
      g = m_ptr;
      while (!req[g]) g = (g + 1) % N;
      m_ptr = (g + 1) % N;
      l = cyc + 1;
      m_tx[l] = 1; m_ack[l] = N'(1) << g; m_wset[l] = 1; m_wval[l] = req_data[g*W +: W]; m_inc[l+1] = 1;
      for (int k = 0; k < 5; k++) m_busy[l+k] = 1;
      for (int k = 1; k < 5; k++) begin m_bv[l+k] = 1; m_idx[l+k] = 2'(k - 1); m_src[l+k] = 3'(g); end
      m_allow = l + 4;
    end
  endfunction

  function void check_cycle();
    if (m_rst[cyc]) begin m_word = '0; m_cnt = 0; end
    if (m_wset[cyc]) m_word = m_wval[cyc];
    if (m_inc[cyc]) m_cnt++;
    chk("tx_out", tx_out, m_tx[cyc]);
    chk("req_ack", req_ack, m_ack[cyc]);
    chk("byte_valid", byte_valid, m_bv[cyc]);
    chk("byte_idx", byte_idx, m_idx[cyc]);
    chk("byte_src", byte_src, m_src[cyc]);
    chk("busy", busy, m_busy[cyc]);
    chk("tx_word", tx_word, m_word);
    chk("words_sent", words_sent, m_cnt % 65536);
    chk("wrap_words_sent", w_words_sent, m_cnt % 16);
    chk("wrap_lane", {w_tx_out, w_req_ack, w_byte_valid, w_byte_idx, w_byte_src, w_busy},
        {m_tx[cyc], m_ack[cyc], m_bv[cyc], m_idx[cyc], m_src[cyc], m_busy[cyc]});
    chk("wrap_tx_word", w_tx_word, m_word);
  endfunction

  task step();
    model_edge();
    @(posedge div_8_clk);
    cyc++;
    @(negedge div_8_clk);
    if (armed) check_cycle();
  endtask

  function vec_t mk(bit r, bit e, bit [3:0] q, bit t, bit [3:0] a, bit v, bit [1:0] i, bit [2:0] s,
                    bit b, bit [31:0] w, int c);
    mk = '{rst_n: r, en: e, req: q, tx: t, ack: a, bv: v, idx: i, src: s, busy: b, word: w, cnt: c};
  endfunction

  initial begin
    int ng, acks, bvs;
    int gid[5], gcy[5];
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    localparam bit [31:0] D0 = 32'h1111_0000, D2 = 32'hA1B2_C3D4, D3 = 32'h3333_3333;
    tv[0]  = mk(0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 4'b0100, 1, 4'b0100, 0, 0, 0, 1, D2, 0);
    tv[2]  = mk(1, 1, 4'b0100, 0, 4'b0000, 1, 0, 2, 1, D2, 1);
    tv[3]  = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 1, 2, 1, D2, 1);
    tv[4]  = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 2, 2, 1, D2, 1);
    tv[5]  = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 3, 2, 1, D2, 1);
    tv[6]  = mk(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, D2, 1);
    tv[7]  = mk(1, 1, 4'b0001, 1, 4'b0001, 0, 0, 0, 1, D0, 1);
    tv[8]  = mk(1, 1, 4'b0001, 0, 4'b0000, 1, 0, 0, 1, D0, 2);
    tv[9]  = mk(1, 1, 4'b1001, 0, 4'b0000, 1, 1, 0, 1, D0, 2);
    tv[10] = mk(1, 1, 4'b1001, 0, 4'b0000, 1, 2, 0, 1, D0, 2);
    tv[11] = mk(1, 1, 4'b1001, 0, 4'b0000, 1, 3, 0, 1, D0, 2);
    tv[12] = mk(1, 1, 4'b1001, 1, 4'b1000, 0, 0, 0, 1, D3, 2);
    tv[13] = mk(1, 1, 4'b1001, 0, 4'b0000, 1, 0, 3, 1, D3, 3);
    tv[14] = mk(1, 1, 4'b0001, 0, 4'b0000, 1, 1, 3, 1, D3, 3);
    tv[15] = mk(1, 1, 4'b0001, 0, 4'b0000, 1, 2, 3, 1, D3, 3);
    tv[16] = mk(1, 1, 4'b0001, 0, 4'b0000, 1, 3, 3, 1, D3, 3);
    tv[17] = mk(1, 1, 4'b0001, 1, 4'b0001, 0, 0, 0, 1, D0, 3);
    tv[18] = mk(1, 1, 4'b0001, 0, 4'b0000, 1, 0, 0, 1, D0, 4);
    tv[19] = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 1, 0, 1, D0, 4);
    tv[20] = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 2, 0, 1, D0, 4);
    tv[21] = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 3, 0, 1, D0, 4);
    tv[22] = mk(1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, D0, 4);
    req_data = {D3, D2, 32'h2222_5555, D0};
    for (int r = 0; r < 23; r++) begin
      rst_n = tv[r].rst_n; sched_en = tv[r].en; req = tv[r].req;
      step();
      chk("tv_tx_out", tx_out, tv[r].tx);
      chk("tv_req_ack", req_ack, tv[r].ack);
      chk("tv_byte_valid", byte_valid, tv[r].bv);
      chk("tv_byte_idx", byte_idx, tv[r].idx);
      chk("tv_byte_src", byte_src, tv[r].src);
      chk("tv_busy", busy, tv[r].busy);
      chk("tv_tx_word", tx_word, tv[r].word);
      chk("tv_words_sent", words_sent, tv[r].cnt);
    end
    // sched_en dropped in the second hold cycle of requester 0's frame
    req = 4'b0001; step();
    chk("en_launch_ack", req_ack, 4'b0001);
    req = 4'b0110; step(); step();
    sched_en = 0; acks = 0; bvs = 0;
    repeat (6) begin step(); acks += (req_ack != '0); bvs += byte_valid; end
    chk("en_drop_acks", acks, 0);
    chk("en_drop_bytes", bvs, 2);
    chk("en_drop_busy", busy, 0);
    sched_en = 1; step();
    chk("en_resume_tx", tx_out, 1);
    chk("en_resume_ack", req_ack, 4'b0010);
    // reset held 3 cycles while a frame is in flight
    rst_n = 0; step();
    chk("rst_zero", {tx_out, req_ack, byte_valid, byte_idx, byte_src, busy, tx_word, words_sent}, '0);
    step(); step();
    rst_n = 1; req = 4'b1111; ng = 0;
    for (int k = 0; k < 40 && ng < 5; k++) begin
      step();
      if (req_ack != '0) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) gid[ng] = i;
        gcy[ng] = cyc; ng++;
      end
    end
    if (ng < 5) begin n_cmp++; n_fail++; $display("FAIL rr_timeout: got %0d grants expected 5", ng); end
    else for (int i = 0; i < 5; i++) begin
      chk("rr_order", gid[i], rr_exp[i]);
      if (i > 0) chk("rr_period", gcy[i] - gcy[i-1], 5);
    end
    for (int k = 0; k < 200 && m_cnt < 17; k++) step();
    chk("wrap_after_17", w_words_sent, 4'd1);
    chk("count_17", words_sent, 16'd17);
    // randomized requesters, sched_en toggling and one mid-run reset
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[cyc][i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 0;
          else req_data[i*W +: W] = $urandom();
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1; req_data[i*W +: W] = $urandom();
        end
      end
      if ($urandom_range(15, 0) == 0) sched_en = ~sched_en;
      rst_n = !(t >= 900 && t < 903);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
